pen_packet_tx: RTL and testbench

- Transmit-side counterpart of the Bluetooth pen receive path. Takes a pen sample (x, y, buttons) and turns it into a 7-byte framed packet, then sends it over an 8N1 UART line.
- The frame format is the one the pen link decoder consumes.
- Uses: hardware loopback of the pen path, echoing cursor/move data to the host, and driving a second board as an emulated pen.

---
 rtl/pen_pkt_pkg.sv | 19 +
 rtl/uart_byte_tx.sv | 58 +++++
 rtl/pen_packet_tx.sv | 101 ++++++++++
 tb/tb_pen_packet_tx.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/pen_pkt_pkg.sv
// Shared definitions for the pen packet link: frame constants, sequencer states
// and the additive checksum used by both the transmit and receive sides.
package pen_pkt_pkg;

  localparam logic [7:0]  PEN_PKT_HEADER = 8'hA5;
  localparam int unsigned PEN_PKT_BYTES  = 7;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} pen_pkt_state_e;

  // Sum of payload bytes B1..B5, wrapping at 8 bits.
  function automatic logic [7:0] pen_pkt_checksum(input logic [11:0] x,
                                                  input logic [11:0] y,
                                                  input logic [7:0]  btn);
    logic [7:0] sum;
    sum = {4'h0, x[11:8]} + x[7:0] + {4'h0, y[11:8]} + y[7:0] + btn;
    return sum;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser. The start bit is driven combinationally in the cycle
// start_i is seen, so the issuing cycle already counts as start-bit cycle 0.
module uart_byte_tx #(
  parameter int unsigned CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       rst_p,
  input  logic [7:0] data_i,
  input  logic       start_i,
  output logic       txd_o,
  output logic       done_o
);

  localparam int unsigned      CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0]    LAST_TICK = CW'(CLK_DIV - 1);

  logic          active;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    data;
  logic          bit_val;

  always_comb begin
    bit_val = 1'b1;
    if (bit_idx == 4'd0)
      bit_val = 1'b0;
    else if (bit_idx <= 4'd8)
      bit_val = data[3'(bit_idx - 4'd1)];
  end

  assign txd_o  = active ? bit_val : ~start_i;
  assign done_o = active && (bit_idx == 4'd9) && (baud_cnt == LAST_TICK);

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      data     <= '0;
    end else if (!active) begin
      if (start_i) begin
        active   <= 1'b1;
        data     <= data_i;
        bit_idx  <= '0;
        baud_cnt <= CW'(1);
      end
    end else if (baud_cnt == LAST_TICK) begin
      baud_cnt <= '0;
      if (bit_idx == 4'd9)
        active <= 1'b0;
      else
        bit_idx <= bit_idx + 4'd1;
    end else begin
      baud_cnt <= baud_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pen_packet_tx.sv
// Pen sample to 7-byte framed packet, sent over an 8N1 UART line.
// Frame: HEADER, x[11:8], x[7:0], y[11:8], y[7:0], btn, checksum.
module pen_packet_tx
  import pen_pkt_pkg::*;
#(
  parameter int unsigned CLK_DIV = 868,
  parameter logic [7:0]  HEADER  = PEN_PKT_HEADER
) (
  input  logic        clk,
  input  logic        rst_p,
  input  logic [11:0] x_i,
  input  logic [11:0] y_i,
  input  logic [7:0]  btn_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        txd_o,
  output logic        busy_o,
  output logic        frame_done_o
);

  localparam logic [2:0] LAST_IDX = 3'(PEN_PKT_BYTES - 1);

  pen_pkt_state_e state, next_state;
  logic [2:0]     idx;
  logic           issue;
  logic [11:0]    x, y;
  logic [7:0]     btn;
  logic [7:0]     cur_byte;
  logic           start;
  logic           byte_done;
  logic           accept;
  logic           advance;

  assign accept  = valid_i && (state == IDLE);
  assign advance = (state == SEND) && byte_done && (idx != LAST_IDX);

  // The next byte is issued one cycle after byte_done, when the serialiser is idle.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state <= IDLE;
      idx   <= '0;
      issue <= 1'b0;
      x     <= '0;
      y     <= '0;
      btn   <= '0;
    end else begin
      state <= next_state;
      issue <= advance;
      if (accept) begin
        x   <= x_i;
        y   <= y_i;
        btn <= btn_i;
        idx <= '0;
      end else if (advance) begin
        idx <= idx + 3'd1;
      end
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (valid_i) next_state = LOAD;
      LOAD: next_state = SEND;
      SEND: if (byte_done && (idx == LAST_IDX)) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready_o      = (state == IDLE);
    busy_o       = (state == LOAD) || (state == SEND);
    frame_done_o = (state == DONE);
    start        = (state == LOAD) || issue;
  end

  always_comb begin
    cur_byte = HEADER;
    unique case (idx)
      3'd0: cur_byte = HEADER;
      3'd1: cur_byte = {4'h0, x[11:8]};
      3'd2: cur_byte = x[7:0];
      3'd3: cur_byte = {4'h0, y[11:8]};
      3'd4: cur_byte = y[7:0];
      3'd5: cur_byte = btn;
      3'd6: cur_byte = pen_pkt_checksum(x, y, btn);
      default: cur_byte = HEADER;
    endcase
  end

  uart_byte_tx #(.CLK_DIV(CLK_DIV)) u_byte_tx (
    .clk     (clk),
    .rst_p   (rst_p),
    .data_i  (cur_byte),
    .start_i (start),
    .txd_o   (txd_o),
    .done_o  (byte_done)
  );

endmodule

// File: tb/tb_pen_packet_tx.sv
// Randomised bench for pen_packet_tx: line is decoded bit by bit and compared
// with frames built from the sample by plain arithmetic.
module tb_pen_packet_tx;

  localparam int unsigned DIV   = 4;
  localparam int unsigned BYTE  = 10 * DIV;
  localparam int unsigned FRAME = 70 * DIV;

  logic        clk = 1'b0;
  logic        rst_p;
  logic [11:0] x_i, y_i;
  logic [7:0]  btn_i;
  logic        valid_i;
  logic        ready_o, txd_o, busy_o, frame_done_o;

  int passed = 0;
  int total  = 0;

  pen_packet_tx #(.CLK_DIV(DIV), .HEADER(8'hA5)) dut (
    .clk          (clk),
    .rst_p        (rst_p),
    .x_i          (x_i),
    .y_i          (y_i),
    .btn_i        (btn_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .txd_o        (txd_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] model_byte(input int k, input logic [11:0] x,
                                            input logic [11:0] y, input logic [7:0] b);
    int p [5];
    int sum;
    p[0] = int'(x) / 256; p[1] = int'(x) % 256;
    p[2] = int'(y) / 256; p[3] = int'(y) % 256;
    p[4] = int'(b);
    sum = p[0] + p[1] + p[2] + p[3] + p[4];
    if (k == 0) return 8'hA5;
    if (k == 6) return 8'(sum % 256);
    return 8'(p[k-1]);
  endfunction

  // Entered at a negedge; returns at the negedge one cycle after frame_done.
  // With chain set, valid_i stays high and inputs churn during the frame.
  task automatic do_frame(input logic [11:0] x, input logic [11:0] y,
                          input logic [7:0] b, input bit chain);
    logic line [FRAME+2];
    bit   frame_ok, ctrl_ok;
    logic [7:0] dec;
    x_i = x; y_i = y; btn_i = b; valid_i = 1'b1;
    check("ready_before_accept", ready_o, 1'b1);
    @(posedge clk);
    ctrl_ok = 1'b1;
    for (int n = 0; n < FRAME + 2; n++) begin
      @(negedge clk);
      line[n] = txd_o;
      if (n < FRAME) begin
        if (ready_o !== 1'b0 || busy_o !== 1'b1 || frame_done_o !== 1'b0) ctrl_ok = 1'b0;
      end else if (n == FRAME) begin
        check("frame_done_pulse", {ready_o, busy_o, frame_done_o}, 3'b001);
      end else begin
        check("ready_after_done", {ready_o, busy_o, frame_done_o}, 3'b100);
      end
      if (!chain) valid_i = 1'b0;
      else if (n < FRAME + 1) begin
        x_i = 12'($urandom); y_i = 12'($urandom); btn_i = 8'($urandom);
      end
    end
    check("ctrl_during_frame", ctrl_ok, 1'b1);
    for (int k = 0; k < 7; k++) begin
      frame_ok = 1'b1;
      dec = '0;
      for (int j = 0; j < 10; j++) begin
        for (int c = 1; c < DIV; c++)
          if (line[k*BYTE + j*DIV + c] !== line[k*BYTE + j*DIV]) frame_ok = 1'b0;
        if (j == 0 && line[k*BYTE] !== 1'b0) frame_ok = 1'b0;
        if (j == 9 && line[k*BYTE + 9*DIV] !== 1'b1) frame_ok = 1'b0;
        if (j >= 1 && j <= 8) dec[j-1] = line[k*BYTE + j*DIV];
      end
      check($sformatf("byte%0d", k), dec, model_byte(k, x, y, b));
      check($sformatf("bit_timing%0d", k), frame_ok, 1'b1);
    end
    check("gap_idle", {line[FRAME], line[FRAME+1]}, 2'b11);
  endtask

  initial begin
    bit fd_seen, tx_low;
    rst_p = 1'b1; valid_i = 1'b0; x_i = '0; y_i = '0; btn_i = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {ready_o, txd_o, busy_o, frame_done_o}, 4'b1100);
    rst_p = 1'b0;

    fd_seen = 1'b0; tx_low = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (frame_done_o) fd_seen = 1'b1;
      if (!txd_o) tx_low = 1'b1;
    end
    check("idle_no_done", fd_seen, 1'b0);
    check("idle_line_high", tx_low, 1'b0);

    do_frame(12'h123, 12'h0AB, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    do_frame(12'hFFF, 12'hFFF, 8'hFF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(1, 5)) @(negedge clk);
      do_frame(12'($urandom), 12'($urandom), 8'($urandom), 1'b0);
    end

    do_frame(12'($urandom), 12'($urandom), 8'($urandom), 1'b1);
    do_frame(12'($urandom), 12'($urandom), 8'($urandom), 1'b1);
    do_frame(12'($urandom), 12'($urandom), 8'($urandom), 1'b0);

    // Reset asserted during the start bit of B3.
    x_i = 12'h456; y_i = 12'h789; btn_i = 8'h3C; valid_i = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= 3 * BYTE + 1; n++) begin
      @(negedge clk);
      valid_i = 1'b0;
    end
    check("pre_reset_txd_low", txd_o, 1'b0);
    #1 rst_p = 1'b1;
    #1 check("async_reset_outputs", {txd_o, ready_o, busy_o}, 3'b110);
    fd_seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (frame_done_o) fd_seen = 1'b1;
    end
    check("reset_no_done", fd_seen, 1'b0);
    rst_p = 1'b0;
    @(negedge clk);
    do_frame(12'($urandom), 12'($urandom), 8'($urandom), 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
